booth_mul_arbiter: RTL and testbench

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/BoothMultiplier.sv | 33 +++
 rtl/booth_mul_arbiter.sv | 115 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/BoothMultiplier.sv
// Combinational 16x16 unsigned multiplier using radix-4 Booth recoding.
// The operands are zero-extended, so nine recoded digits cover the full 32-bit product.
module BoothMultiplier (
  output logic [31:0] result,
  input  logic [15:0] x,
  input  logic [15:0] y
);

  logic [18:0] yb;
  logic [31:0] xe;
  logic [31:0] pp;
  logic [31:0] acc;

  always_comb begin
    yb  = {2'b00, y, 1'b0};
    xe  = {16'b0, x};
    acc = '0;
    pp  = '0;
    for (int i = 0; i < 9; i++) begin
      case (yb[2*i +: 3])
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe << 1;
        3'b100:         pp = -(xe << 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      // Modulo-2^32 accumulation is exact because the true product fits in 32 bits.
      acc = acc + (pp << (2 * i));
    end
    result = acc;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Two-requester round-robin front end sharing one Booth multiplier.
// Operands are registered at accept and held LAT cycles before the product is captured.
module booth_mul_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  in_valid,
  output logic [1:0]  in_ready,
  input  logic [15:0] in_x0,
  input  logic [15:0] in_y0,
  input  logic [15:0] in_x1,
  input  logic [15:0] in_y1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_prod,
  output logic        out_id,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] opx_q, opx_d, opy_q, opy_d;
  logic        lg_q, lg_d;
  logic        id_q, id_d;
  logic        valid_q, valid_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] mul_res;
  logic [1:0]  grant;

  BoothMultiplier u_mul (
    .result (mul_res),
    .x      (opx_q),
    .y      (opy_q)
  );

  // Contention goes to the requester that was not served last.
  always_comb begin
    grant = in_valid;
    if (in_valid == 2'b11) grant = lg_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    lg_d     = lg_q;
    id_d     = id_q;
    valid_d  = valid_q;
    prod_d   = prod_q;
    in_ready = 2'b00;
    case (state_q)
      StIdle: begin
        in_ready = rst_n ? grant : 2'b00;
        if (grant != 2'b00) begin
          opx_d   = grant[1] ? in_x1 : in_x0;
          opy_d   = grant[1] ? in_y1 : in_y0;
          id_d    = grant[1];
          lg_d    = grant[1];
          cnt_d   = CntInit;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 4'd0) begin
          prod_d  = mul_res;
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opx_q   <= '0;
      opy_q   <= '0;
      lg_q    <= 1'b1;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opx_q   <= opx_d;
      opy_q   <= opy_d;
      lg_q    <= lg_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      prod_q  <= prod_d;
    end
  end

  assign out_valid = valid_q;
  assign out_prod  = prod_q;
  assign out_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_booth_mul_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  in_ready;
  logic [15:0] in_x0 = '0, in_y0 = '0, in_x1 = '0, in_y1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_prod;
  logic        out_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  booth_mul_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x0     (in_x0),
    .in_y0     (in_y0),
    .in_x1     (in_x1),
    .in_y1     (in_y1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Transaction model: one job in flight, result LAT edges after accept,
  // released on the first out_ready edge, accept only while no job is held.
  logic        m_have, m_ov, m_id, m_lg;
  logic [31:0] m_prod, m_job;
  int          m_cyc, m_tacc;
  logic [1:0]  m_rdy;

  function automatic logic [1:0] pick(input logic [1:0] v, input logic lg);
    if (v == 2'b11) return lg ? 2'b01 : 2'b10;
    return v;
  endfunction

  assign m_rdy = (m_have || !rst_n) ? 2'b00 : pick(in_valid, m_lg);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have <= 1'b0;
      m_ov   <= 1'b0;
      m_id   <= 1'b0;
      m_lg   <= 1'b1;
      m_prod <= '0;
      m_job  <= '0;
      m_cyc  <= 0;
      m_tacc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_ov) begin
        if (out_ready) begin
          m_ov   <= 1'b0;
          m_have <= 1'b0;
        end
      end else if (m_have) begin
        if (m_cyc == m_tacc + int'(LAT)) begin
          m_ov   <= 1'b1;
          m_prod <= m_job;
        end
      end else if (m_rdy != 2'b00) begin
        m_have <= 1'b1;
        m_tacc <= m_cyc;
        m_id   <= m_rdy[1];
        m_lg   <= m_rdy[1];
        m_job  <= m_rdy[1] ? 32'(in_x1) * 32'(in_y1) : 32'(in_x0) * 32'(in_y0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
    chk("cyc_busy", 32'(busy), 32'(m_have));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
    chk("cyc_out_id", 32'(out_id), 32'(m_id));
    chk("cyc_out_prod", out_prod, m_prod);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int         acc_n[2];
    logic       acc_id[2];
    logic [31:0] prods[2];
    logic       ids[2];
    int         na, np, nacc, sweep_ok, sweep_bad, k;
    logic [1:0] hs;
    logic       stop;
    logic [15:0] x, y;

    // Reset state, with requests pending during reset.
    in_valid = 2'b11;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", out_prod, 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);

    // Single request, accepted on the first edge after release.
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 2'b01;
    in_x0    = 16'd1000;
    in_y0    = 16'd2000;
    out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 2'b00;
    chk("t1_busy_calc", 32'(busy), 32'd1);
    tick();
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_prod", out_prod, 32'd2000000);
    chk("t1_id", 32'(out_id), 32'd0);
    tick();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_valid_low", 32'(out_valid), 32'd0);

    // Contention straight after reset: r0 first, r1 LAT+2 cycles later.
    do_reset();
    in_x0 = 16'hFFFF;
    in_y0 = 16'hFFFF;
    in_x1 = 16'd3;
    in_y1 = 16'd7;
    in_valid = 2'b11;
    out_ready = 1'b1;
    na = 0;
    np = 0;
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_n[i] = 0; acc_id[i] = 1'b0; prods[i] = '0; ids[i] = 1'b0;
    end
    for (int n = 0; n < 16; n++) begin
      #2;
      hs = in_valid & in_ready;
      if (hs != 2'b00 && na < 2) begin
        acc_n[na]  = n;
        acc_id[na] = hs[1];
        na++;
        if (na == 2) stop = 1'b1;
      end
      tick();
      if (stop) in_valid = 2'b00;
      if (out_valid && np < 2) begin
        prods[np] = out_prod;
        ids[np]   = out_id;
        np++;
      end
    end
    chk("t2_accepts", 32'(na), 32'd2);
    chk("t2_products", 32'(np), 32'd2);
    chk("t2_first_id", 32'(acc_id[0]), 32'd0);
    chk("t2_second_id", 32'(acc_id[1]), 32'd1);
    chk("t2_interval", 32'(acc_n[1] - acc_n[0]), 32'(LAT + 2));
    chk("t2_prod0", prods[0], 32'hFFFE0001);
    chk("t2_id0", 32'(ids[0]), 32'd0);
    chk("t2_prod1", prods[1], 32'd21);
    chk("t2_id1", 32'(ids[1]), 32'd1);
    tick();

    // Back-pressure in DONE with inputs toggling.
    out_ready = 1'b0;
    in_x1 = 16'd123;
    in_y1 = 16'd456;
    in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    wait_out("t3_timeout", LAT + 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 2'(i + 1);
      in_x0 = 16'(i * 777);
      in_x1 = 16'(i * 999 + 1);
      in_y1 = 16'(i + 5);
      #1;
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("t3_prod_hold", out_prod, 32'd56088);
      chk("t3_id_hold", 32'(out_id), 32'd1);
      chk("t3_valid_hold", 32'(out_valid), 32'd1);
    end
    in_valid = 2'b00;
    out_ready = 1'b1;
    tick();
    chk("t3_release", 32'(out_valid), 32'd0);

    // Reset mid-CALC: outputs clear asynchronously and no product follows.
    in_x1 = 16'd300;
    in_y1 = 16'd400;
    in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_out_prod", out_prod, 32'd0);
    chk("t4_out_id", 32'(out_id), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_product", 32'(out_valid), 32'd0);
    end

    // Operand sweep through alternating requesters.
    sweep_ok = 0;
    sweep_bad = 0;
    k = 0;
    for (int xi = 0; xi < 66; xi++) begin
      for (int yi = 0; yi < 66; yi++) begin
        x = 16'(xi * 1000);
        y = 16'(yi * 1000);
        if (k % 2 == 0) begin
          in_x0 = x; in_y0 = y; in_valid = 2'b01;
        end else begin
          in_x1 = x; in_y1 = y; in_valid = 2'b10;
        end
        tick();
        in_valid = 2'b00;
        wait_out("sweep_timeout", LAT + 3);
        if (out_prod === 32'(x) * 32'(y)) sweep_ok++;
        else sweep_bad++;
        chk("sweep_prod", out_prod, 32'(x) * 32'(y));
        chk("sweep_id", 32'(out_id), 32'(k % 2));
        tick();
        k++;
      end
    end
    $display("sweep: correct=%0d wrong=%0d", sweep_ok, sweep_bad);

    // Requester 1 alone is granted every slot.
    nacc = 0;
    in_x1 = 16'd11;
    in_y1 = 16'd13;
    in_valid = 2'b10;
    for (int n = 0; n < 4 * (LAT + 2); n++) begin
      #2;
      if ((in_valid & in_ready) == 2'b10) nacc++;
      tick();
    end
    in_valid = 2'b00;
    chk("t6_r1_accepts", 32'(nacc), 32'd4);
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
